// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI video timing generator.
package hdmi_timing_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][23:0] TPG_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdmi_video_timing.sv
// Video timing generator: waits for PLL lock, settles, then free-runs h/v counters.
// Define HDMI_TIMING_TPG_EN to add a registered colour-bar rgb output.
module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE    = 320,
  parameter int H_FP        = 8,
  parameter int H_SYNC      = 32,
  parameter int H_BP        = 40,
  parameter int V_ACTIVE    = 240,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 15,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_SETTLE = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             running
`ifdef HDMI_TIMING_TPG_EN
  ,
  output logic [23:0]      rgb
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG   = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_BEG + H_SYNC;
  localparam int VS_BEG   = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_BEG + V_SYNC;
  localparam int SET_W    = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || LOCK_SETTLE < 1) begin : g_bad_cfg
    $error("hdmi_video_timing: totals must fit 12-bit counters and LOCK_SETTLE >= 1");
  end

  logic             lock_s;
  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             out_en, active, hs, vs;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, run_q, run_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      set_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_s) state_d = SETTLE;
      SETTLE: begin
        if (!lock_s)                                  state_d = WAIT_LOCK;
        else if (int'(set_q) == LOCK_SETTLE - 1)      state_d = RUN;
      end
      RUN:     if (!lock_s) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Counters sit at zero everywhere except while actively settling or running.
  always_comb begin
    set_d = '0;
    h_d   = '0;
    v_d   = '0;
    if (state_q == SETTLE && lock_s) set_d = set_q + SET_W'(1);
    if (state_q == RUN && lock_s) begin
      if (int'(h_q) == H_TOTAL - 1) begin
        v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
      end
    end
  end

  always_comb begin
    out_en = (state_q == RUN) && lock_s;
    active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    hs     = (int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END);
    vs     = (int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END);
    de_d   = out_en && active;
    hs_d   = (out_en && hs) ? SYNC_POL : ~SYNC_POL;
    vs_d   = (out_en && vs) ? SYNC_POL : ~SYNC_POL;
    x_d    = de_d ? h_q : '0;
    y_d    = de_d ? v_q : '0;
    fs_d   = out_en && (h_q == '0) && (v_q == '0);
    run_d  = out_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      run_q <= run_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign running     = run_q;

`ifdef HDMI_TIMING_TPG_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  int          bar;
  logic [2:0]  bar_sel;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    bar     = int'(h_q) / BAR_W;
    bar_sel = (bar > 7) ? 3'd7 : 3'(bar);
    rgb_d   = de_d ? TPG_BARS[bar_sel] : 24'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Self-checking bench: randomized lock/reset events against an arithmetic frame model.
module tb_hdmi_video_timing;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 5,  VF = 1, VS = 2, VB = 2;
  localparam bit POL = 1'b0;
  localparam int LS  = 16;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int LAT = 2 + LS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic        hsync, vsync, de, frame_start, running;
  logic [11:0] x, y;
`ifdef HDMI_TIMING_TPG_EN
  logic [23:0] rgb;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int k;
  int c;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .LOCK_SETTLE(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .running(running)
`ifdef HDMI_TIMING_TPG_EN
    , .rgb(rgb)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] obs();
    logic [63:0] v = '0;
    v[23:12] = x;
    v[11:0]  = y;
    v[24] = vsync; v[25] = hsync; v[26] = de; v[27] = frame_start; v[28] = running;
`ifdef HDMI_TIMING_TPG_EN
    v[55:32] = rgb;
`endif
    return v;
  endfunction

  function automatic logic [63:0] idle_vec();
    logic [63:0] v = '0;
    v[24] = ~POL; v[25] = ~POL;
    return v;
  endfunction

  // Expected outputs for the kk-th clock after running first rises.
  function automatic logic [63:0] exp_pix(int kk);
    logic [63:0] v = '0;
    int pos = kk % (HT * VT);
    int h = pos % HT;
    int l = pos / HT;
    bit act = (h < HA) && (l < VA);
    int b = h / (HA / 8);
    if (b > 7) b = 7;
    v[23:12] = act ? 12'(h) : 12'd0;
    v[11:0]  = act ? 12'(l) : 12'd0;
    v[25] = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
    v[24] = (l >= VA + VF && l < VA + VF + VS) ? POL : ~POL;
    v[26] = act;
    v[27] = (pos == 0);
    v[28] = 1'b1;
`ifdef HDMI_TIMING_TPG_EN
    v[55:32] = act ? bars[b] : 24'h0;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(input int n);
    repeat (n) begin
      tick();
      chk("pix", obs(), exp_pix(k));
      k++;
    end
  endtask

  // Caller changes inputs at a negedge; the first tick here is the first sampling edge.
  task automatic wait_run(output int cnt);
    cnt = 0;
    while (cnt < 200) begin
      tick();
      cnt++;
      if (running) break;
      chk("settle_idle", obs(), idle_vec());
    end
    chk("lock_latency", 64'(cnt - 1), 64'(LAT));
    k = 0;
    chk("first_pix", obs(), exp_pix(k));
    k = 1;
  endtask

  task automatic hold_idle(input string tag, input int n);
    repeat (n) begin
      tick();
      chk(tag, obs(), idle_vec());
    end
  endtask

  initial begin
    pll_locked = 1'b1;
    #23;
    chk("reset_idle", obs(), idle_vec());
    hold_idle("reset_hold", 2);

    @(negedge clk) rst_n = 1'b1;
    wait_run(c);
    run_model($urandom_range(300, 600));

    // Lock loss while running: two more decoded clocks, then idle.
    @(negedge clk) pll_locked = 1'b0;
    run_model(2);
    tick();
    chk("lock_loss_idle", obs(), idle_vec());
    hold_idle("lock_low", $urandom_range(3, 20));

    // Relock, then drop lock during SETTLE: settle must restart in full.
    @(negedge clk) pll_locked = 1'b1;
    hold_idle("settle_part", $urandom_range(4, 12));
    @(negedge clk) pll_locked = 1'b0;
    hold_idle("settle_abort", 5);
    @(negedge clk) pll_locked = 1'b1;
    wait_run(c);
    run_model($urandom_range(250, 500));

    // Asynchronous reset in the active region.
    c = 0;
    while (!de && c < HT * VT) begin
      tick();
      chk("pix_seek", obs(), exp_pix(k));
      k++;
      c++;
    end
    chk("seek_active", 64'(de), 64'(1));
    #3 rst_n = 1'b0;
    #1 chk("async_reset", obs(), idle_vec());
    @(negedge clk) rst_n = 1'b1;
    wait_run(c);
    run_model(2 * HT * VT + $urandom_range(0, 100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
